// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the datapath and the multiply/divide unit
// Ports (via modports):
//   master -> drives start, alu_control, operand_a, operand_b; observes busy, done, div_zero, hi, lo
//   slave  -> the execution unit; the reverse directions
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       alu_control;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_control, operand_a, operand_b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, alu_control, operand_a, operand_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed mult/div unit writing the architectural HI/LO registers
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus (slave)    start, alu_control {alu_op,alu_func}, operand_a (rs), operand_b (rt) in;
//                  busy, done (1-cycle pulse), div_zero (with done), hi, lo out
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, raw_q, raw_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sa_q, sa_d, sb_q, sb_d, div_q, div_d, dz_q, dz_d;
    logic               busy_q, busy_d, done_q, done_d, dzo_q, dzo_d;

    logic               is_mult, is_div, accept;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;

    assign is_mult = bus.alu_control == 6'b10_0011;
    assign is_div  = bus.alu_control == 6'b10_0100;
    assign accept  = bus.start && state_q == IDLE && (is_mult || is_div);
    assign abs_a   = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    assign abs_b   = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

    // Multiply: acc = {partial product, remaining multiplier bits}; add on the low bit, shift right
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract, keep if no borrow
    assign div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    assign div_step = div_diff[WIDTH]
                    ? {acc_q[2*WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        raw_d   = raw_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        dz_d    = dz_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    a_d     = abs_a;
                    b_d     = abs_b;
                    raw_d   = bus.operand_a;
                    sa_d    = bus.operand_a[WIDTH-1];
                    sb_d    = bus.operand_b[WIDTH-1];
                    div_d   = is_div;
                    dz_d    = is_div && bus.operand_b == '0;
                    acc_d   = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
                end
            end
            CALC: begin
                acc_d   = div_q ? div_step : mul_step;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                if (!div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = raw_q;
                    lo_d = '1;
                end else begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign
                    lo_d = (sa_q ^ sb_q) ? -quo : quo;
                    hi_d = sa_q ? -rem : rem;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            raw_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            raw_q   <= raw_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dzo_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    localparam logic [5:0] MULT = 6'b10_0011;
    localparam logic [5:0] DIV  = 6'b10_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int   n_cmp = 0;
    int   n_err = 0;
    int   lat, bcnt, stray;
    logic dz_seen;

    task automatic launch(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.alu_control = c;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        lat = -1;
        bcnt = bus.busy ? 1 : 0;
        dz_seen = 1'b0;
        stray = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) bcnt++;
            if (bus.div_zero && !bus.done) stray++;
            if (bus.done) begin
                lat = i;
                dz_seen = bus.div_zero;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        launch(c, a, b);
        wait_done();
    endtask

    task automatic watch_quiet(output int busy_seen, output int done_seen);
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_seen++;
            if (bus.done) done_seen++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", bus.div_zero); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        run_op(MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency got %0d want 33", lat); end
        n_cmp++; if (bcnt !== 33) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 33", bcnt); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_div();
        run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency got %0d want 33", lat); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
        n_cmp++; if (dz_seen !== 1'b0) begin n_err++; $display("FAIL div_dz got %b want 0", dz_seen); end
    endtask

    task automatic test_div_zero();
        run_op(DIV, 32'h0000_0064, 32'h0000_0000);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dz_latency got %0d want 33", lat); end
        n_cmp++; if (dz_seen !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", dz_seen); end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL dz_early got %0d want 0", stray); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h0000_0064) begin n_err++; $display("FAIL dz_hi got %h want 00000064", bus.hi); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL dz_pulse got %b want 0", bus.div_zero); end
    endtask

    task automatic test_ignored();
        logic [5:0] ctl [2] = '{6'b10_0010, 6'b00_0011};
        int bs, ds;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            launch(ctl[k], 32'h5, 32'h5);
            watch_quiet(bs, ds);
            n_cmp++; if (bs !== 0) begin n_err++; $display("FAIL ignore_busy ctl=%b got %0d want 0", ctl[k], bs); end
            n_cmp++; if (ds !== 0) begin n_err++; $display("FAIL ignore_done ctl=%b got %0d want 0", ctl[k], ds); end
        end
        n_cmp++; if (bus.hi !== 32'h0000_0064) begin n_err++; $display("FAIL ignore_hi got %h want 00000064", bus.hi); end
    endtask

    task automatic test_busy_ignore();
        int bs, ds;
        @(negedge clk);
        launch(MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (5) @(negedge clk);
        launch(MULT, 32'h2, 32'h2);
        wait_done();
        n_cmp++; if (lat !== 28) begin n_err++; $display("FAIL busy_ign_latency got %0d want 28", lat); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL busy_ign_lo got %h want ffffffeb", bus.lo); end
        watch_quiet(bs, ds);
        n_cmp++; if (ds !== 0) begin n_err++; $display("FAIL busy_ign_second_done got %0d want 0", ds); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL busy_ign_lo_held got %h want ffffffeb", bus.lo); end
    endtask

    task automatic test_reset_mid_op();
        int bs, ds;
        @(negedge clk);
        launch(MULT, 32'h0000_0009, 32'h0000_0009);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rst_mid_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_lo got %h want 0", bus.lo); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(bs, ds);
        n_cmp++; if (ds !== 0) begin n_err++; $display("FAIL rst_mid_done got %0d want 0", ds); end
        n_cmp++; if (bs !== 0) begin n_err++; $display("FAIL rst_mid_busy_after got %0d want 0", bs); end
        run_op(MULT, 32'h3, 32'h4);
        n_cmp++; if (bus.lo !== 32'h0000_000C) begin n_err++; $display("FAIL rst_mult_lo got %h want 0000000c", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rst_mult_hi got %h want 0", bus.hi); end
    endtask

    task automatic test_corners();
        run_op(MULT, 32'h8000_0000, 32'h8000_0000);
        n_cmp++; if (bus.hi !== 32'h4000_0000) begin n_err++; $display("FAIL min_sq_hi got %h want 40000000", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL min_sq_lo got %h want 0", bus.lo); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (bus.lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo got %h want 80000000", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL ovf_hi got %h want 0", bus.hi); end
        n_cmp++; if (dz_seen !== 1'b0) begin n_err++; $display("FAIL ovf_dz got %b want 0", dz_seen); end
        run_op(DIV, 32'h0000_0011, 32'hFFFF_FFFB);
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_pn_lo got %h want fffffffd", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h0000_0002) begin n_err++; $display("FAIL div_pn_hi got %h want 00000002", bus.hi); end
    endtask

    task automatic test_back_to_back();
        run_op(MULT, 32'h5, 32'h6);
        n_cmp++; if (bus.lo !== 32'h0000_001E) begin n_err++; $display("FAIL b2b_first_lo got %h want 0000001e", bus.lo); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", bus.done); end
        launch(MULT, 32'hFFFF_FFFE, 32'h0000_0009);
        wait_done();
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", lat); end
        n_cmp++; if (bcnt !== 33) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 33", bcnt); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_hi got %h want ffffffff", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFEE) begin n_err++; $display("FAIL b2b_lo got %h want ffffffee", bus.lo); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.alu_control = 6'b0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_busy_ignore();
        test_reset_mid_op();
        test_corners();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
